// File: rtl/ext_mem_loader_pkg.sv
// Shared types and address helpers for the external-memory loader.
package ext_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    RUN,
    DREQ,
    DWAIT,
    DOUT
  } state_t;

  localparam int IMEM_BYTE_SHIFT = 2;
  localparam int DMEM_BYTE_SHIFT = 3;

  function automatic logic [63:0] imem_byte_addr(input logic [63:0] word_idx);
    return word_idx << IMEM_BYTE_SHIFT;
  endfunction

  function automatic logic [63:0] dmem_byte_addr(input logic [63:0] word_idx);
    return word_idx << DMEM_BYTE_SHIFT;
  endfunction

endpackage

// File: rtl/ext_mem_loader_down_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
module loader_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (srst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side loader: streams a program into IMEM, runs the CPU, dumps a DMEM window.
// Optional readback checksum of the loaded program under EXT_MEM_LOADER_VERIFY_EN.
//
// state  | meaning
// IDLE   | waiting for start; parameters latched on accept
// LOAD   | accepting program words, one IMEM write per handshake
// VERIFY | re-reading IMEM and accumulating the readback checksum
// RUN    | cpu_enable held high for run_cycles cycles
// DREQ   | one-cycle DMEM read strobe
// DWAIT  | read latency wait, data captured on the last cycle
// DOUT   | presenting a dump word until the sink accepts it
module ext_mem_loader
  import ext_mem_loader_pkg::*;
#(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   start,
  input  logic [IMEM_ADDR_W:0]   load_words,
  input  logic [31:0]            run_cycles,
  input  logic [DMEM_ADDR_W-1:0] dump_base,
  input  logic [DMEM_ADDR_W:0]   dump_words,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic                   cpu_enable,
  output logic [63:0]            addr_ext,
  output logic                   wen_ext,
  output logic                   ren_ext,
  output logic [31:0]            wdata_ext,
  input  logic [31:0]            rdata_ext,
  output logic [63:0]            addr_ext_2,
  output logic                   wen_ext_2,
  output logic                   ren_ext_2,
  output logic [63:0]            wdata_ext_2,
  input  logic [63:0]            rdata_ext_2,
  output logic                   busy,
  output logic                   done,
  output logic                   verify_err
);

  localparam int LW    = IMEM_ADDR_W + 1;
  localparam int DW    = DMEM_ADDR_W + 1;
  localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

  state_t state, state_nx;

  logic                   start_acc, load_hs, out_hs, dump_last;
  logic                   load_zero, run_zero, lat_zero, dump_zero;
  logic [LW-1:0]          load_cnt, load_cnt_val;
  logic [DW-1:0]          dump_cnt;
  logic [31:0]            run_cnt;
  logic [LAT_W-1:0]       lat_cnt;
  logic [IMEM_ADDR_W-1:0] widx;
  logic [DMEM_ADDR_W-1:0] dump_base_q, k, dump_idx;
  logic                   v_issue, v_waiting, v_cap, v_reload;
  logic                   unused_cnt;

  assign start_acc = (state == IDLE) && start;
  assign in_ready  = (state == LOAD) && !load_zero;
  assign load_hs   = in_ready && in_valid;
  assign out_valid = (state == DOUT);
  assign out_hs    = out_valid && out_ready;
  assign dump_last = (dump_cnt == DW'(1));
  assign dump_idx  = dump_base_q + k;

  assign wen_ext     = load_hs;
  assign wdata_ext   = load_hs ? in_data : '0;
  assign addr_ext    = (load_hs || v_issue) ? imem_byte_addr(64'(widx)) : '0;
  assign cpu_enable  = (state == RUN) && !run_zero;
  assign ren_ext_2   = (state == DREQ);
  assign addr_ext_2  = ren_ext_2 ? dmem_byte_addr(64'(dump_idx)) : '0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = '0;
  assign busy        = (state != IDLE);
  assign done        = ((state == RUN) && run_zero && dump_zero) || (out_hs && dump_last);
  assign unused_cnt  = ^{load_cnt, run_cnt, lat_cnt};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD: begin
        if (load_zero) begin
`ifdef EXT_MEM_LOADER_VERIFY_EN
          state_nx = VERIFY;
`else
          state_nx = RUN;
`endif
        end
      end
`ifdef EXT_MEM_LOADER_VERIFY_EN
      VERIFY: if (!v_waiting && !v_issue && load_zero) state_nx = RUN;
`endif
      RUN:   if (run_zero) state_nx = dump_zero ? IDLE : DREQ;
      DREQ:  state_nx = DWAIT;
      DWAIT: if (lat_zero) state_nx = DOUT;
      DOUT:  if (out_hs) state_nx = dump_last ? IDLE : DREQ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      widx        <= '0;
      k           <= '0;
      dump_base_q <= '0;
      out_data    <= '0;
    end else begin
      state <= state_nx;
      if (start_acc) begin
        dump_base_q <= dump_base;
        k           <= '0;
        widx        <= '0;
      end else begin
        if (load_hs || v_cap) widx <= widx + IMEM_ADDR_W'(1);
        else if (v_reload)    widx <= '0;
        if (out_hs) k <= k + DMEM_ADDR_W'(1);
      end
      if ((state == DWAIT) && lat_zero) out_data <= rdata_ext_2;
    end
  end

`ifdef EXT_MEM_LOADER_VERIFY_EN
  logic [LW-1:0] load_words_q;
  logic [31:0]   wr_sum, rd_sum;
  logic          v_wait, verify_err_q;

  assign v_issue      = (state == VERIFY) && !v_wait && !load_zero;
  assign v_waiting    = (state == VERIFY) && v_wait;
  assign v_cap        = v_waiting && lat_zero;
  assign v_reload     = (state == LOAD) && load_zero;
  assign load_cnt_val = start_acc ? load_words : load_words_q;
  assign ren_ext      = v_issue;
  assign verify_err   = verify_err_q;

  // Checksums stand in for a copy of the program; compared once all readbacks are in.
  always_ff @(posedge clk) begin
    if (srst) begin
      load_words_q <= '0;
      wr_sum       <= '0;
      rd_sum       <= '0;
      v_wait       <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      if (start_acc) begin
        load_words_q <= load_words;
        wr_sum       <= '0;
        rd_sum       <= '0;
      end
      if (load_hs) wr_sum <= wr_sum ^ in_data;
      if (v_issue) begin
        v_wait <= 1'b1;
      end else if (v_cap) begin
        v_wait <= 1'b0;
        rd_sum <= rd_sum ^ rdata_ext;
      end
      if ((state == VERIFY) && !v_wait && load_zero && (wr_sum != rd_sum))
        verify_err_q <= 1'b1;
    end
  end
`else
  logic unused_rdata;

  assign v_issue      = 1'b0;
  assign v_waiting    = 1'b0;
  assign v_cap        = 1'b0;
  assign v_reload     = 1'b0;
  assign load_cnt_val = load_words;
  assign ren_ext      = 1'b0;
  assign verify_err   = 1'b0;
  assign unused_rdata = ^rdata_ext;
`endif

  loader_down_counter #(.W(LW)) u_load_cnt (
    .clk      (clk),
    .srst     (srst),
    .load     (start_acc || v_reload),
    .load_val (load_cnt_val),
    .dec      (load_hs || v_cap),
    .count    (load_cnt),
    .zero     (load_zero)
  );

  loader_down_counter #(.W(32)) u_run_cnt (
    .clk      (clk),
    .srst     (srst),
    .load     (start_acc),
    .load_val (run_cycles),
    .dec      (state == RUN),
    .count    (run_cnt),
    .zero     (run_zero)
  );

  loader_down_counter #(.W(LAT_W)) u_lat_cnt (
    .clk      (clk),
    .srst     (srst),
    .load     (ren_ext_2 || v_issue),
    .load_val (LAT_W'(RD_LAT - 1)),
    .dec      ((state == DWAIT) || v_waiting),
    .count    (lat_cnt),
    .zero     (lat_zero)
  );

  loader_down_counter #(.W(DW)) u_dump_cnt (
    .clk      (clk),
    .srst     (srst),
    .load     (start_acc),
    .load_val (dump_words),
    .dec      (out_hs),
    .count    (dump_cnt),
    .zero     (dump_zero)
  );

endmodule

// File: tb/tb_ext_mem_loader.sv
// Scoreboard bench for ext_mem_loader: random program/dump runs against simple memory models.
module tb_ext_mem_loader;

  logic        clk = 1'b0;
  logic        srst, start;
  logic [9:0]  load_words;
  logic [31:0] run_cycles;
  logic [9:0]  dump_base;
  logic [10:0] dump_words;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        cpu_enable;
  logic [63:0] addr_ext, addr_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext, rdata_ext;
  logic [63:0] wdata_ext_2, rdata_ext_2;
  logic        busy, done, verify_err;

  always #5 clk = ~clk;

  ext_mem_loader dut (
    .clk(clk), .srst(srst), .start(start), .load_words(load_words),
    .run_cycles(run_cycles), .dump_base(dump_base), .dump_words(dump_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext),
    .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done), .verify_err(verify_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected event want none", nm);
  endtask

  // Memory models: synchronous read, one cycle latency.
  logic [31:0] imem [0:511];
  logic [63:0] dmem [0:1023];
  int          flip_idx = -1;

  always @(posedge clk) begin
    if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
    if (ren_ext)
      rdata_ext <= imem[addr_ext[10:2]] ^ ((int'(addr_ext[10:2]) == flip_idx) ? 32'h1 : 32'h0);
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
  end

  typedef struct { logic [63:0] a; logic [63:0] d; } wr_t;
  wr_t         wr_q[$];
  logic [63:0] ra_q[$];
  logic [63:0] rd_q[$];
  logic [31:0] feed_q[$];
  int          en_cnt, done_cnt;
  bit          mon_en = 0;
  bit          exp_verr = 0;
  int          sink_mode = 0;
  int          stall = 0;

  // Sink: 0 always ready, 1 random, 2 hold off 3 cycles per word, other never ready.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          stall = out_valid ? stall + 1 : 0;
          out_ready = (stall > 3);
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  wr_t         e;
  logic [63:0] held_data;
  bit          held_v = 0;

  always @(negedge clk) begin
    if (srst) begin
      held_v = 0;
    end else if (mon_en) begin
      if (wen_ext || (in_valid && in_ready)) begin
        chk("wen_on_handshake", wen_ext, in_valid && in_ready);
        if (wr_q.size() == 0) fail("unexpected_imem_write");
        else begin
          e = wr_q.pop_front();
          chk("imem_addr", addr_ext, e.a);
          chk("imem_data", wdata_ext, e.d);
        end
      end
      if (cpu_enable) begin
        en_cnt++;
        chk("enable_exclusive", {wen_ext, ren_ext_2}, 0);
      end
      if (ren_ext_2) begin
        if (ra_q.size() == 0) fail("unexpected_dmem_read");
        else chk("dmem_addr", addr_ext_2, ra_q.pop_front());
      end
      if (held_v) begin
        chk("out_hold_valid", out_valid, 1);
        chk("out_hold_data", out_data, held_data);
      end
      held_v = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        if (rd_q.size() == 0) fail("unexpected_dump_word");
        else begin
          chk("dump_data", out_data, rd_q.pop_front());
          chk("done_on_last", done, rd_q.size() == 0);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic prime(input int nw, input int rc, input int base, input int nd);
    feed_q.delete();
    for (int i = 0; i < nw; i++) begin
      logic [31:0] w;
      w = $urandom;
      feed_q.push_back(w);
      wr_q.push_back('{a: 64'(i * 4), d: 64'(w)});
    end
    for (int j = 0; j < nd; j++) begin
      int a;
      a = (base + j) % 1024;
      ra_q.push_back(64'(a * 8));
      rd_q.push_back(dmem[a]);
    end
    en_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    load_words = 10'(nw);
    run_cycles = 32'(rc);
    dump_base = 10'(base);
    dump_words = 11'(nd);
    @(posedge clk); #1;
    start = 1'b0;
    load_words = 10'($urandom);
    run_cycles = $urandom;
    dump_base = 10'($urandom);
    dump_words = 11'($urandom);
  endtask

  task automatic feed(input int vmode);
    int i = 0;
    int cyc = 0;
    bit hs;
    while (i < feed_q.size()) begin
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = feed_q[i];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
      if (cyc > 4000) begin
        fail("load_timeout");
        break;
      end
    end
    in_valid = 1'b0;
    in_data = '0;
    if (feed_q.size() > 0) begin
      @(negedge clk);
      chk("in_ready_after_load", in_ready, 0);
    end
  endtask

  task automatic finish_run(input int rc);
    int g = 0;
    while (busy && g < 20000) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) fail("busy_timeout");
    @(negedge clk);
    chk("enable_cycles", en_cnt, rc);
    chk("done_count", done_cnt, 1);
    chk("writes_left", wr_q.size(), 0);
    chk("reads_left", ra_q.size(), 0);
    chk("dumps_left", rd_q.size(), 0);
    chk("verify_err", verify_err, exp_verr);
  endtask

  task automatic do_run(input int nw, input int vmode, input int rc, input int base,
                        input int nd, input int smode, input bit poke);
    sink_mode = smode;
    prime(nw, rc, base, nd);
    feed(vmode);
    if (poke) begin
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    finish_run(rc);
    if (poke) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stray_start_ignored", busy, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int g;
    srst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    load_words = '0; run_cycles = '0; dump_base = '0; dump_words = '0;
    for (int i = 0; i < 1024; i++) dmem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cpu_enable", cpu_enable, 0);
    chk("rst_wen_ext", wen_ext, 0);
    chk("rst_ren_ext_2", ren_ext_2, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_verify_err", verify_err, 0);
    chk("rst_out_data", out_data, 0);
    mon_en = 1;

    do_run(4, 0, 10, 0, 3, 0, 0);
    do_run(6, 1, 0, 5, 2, 1, 0);
    do_run(0, 0, 3, 1023, 2, 2, 0);
    do_run(5, 2, 20, 300, 0, 0, 1);
    do_run(0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 5; r++)
      do_run($urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, 30),
             $urandom_range(0, 1023), $urandom_range(0, 6), $urandom_range(0, 2), 0);

    // Abort while a dump word is waiting on the sink.
    sink_mode = 3;
    prime(0, 2, 7, 3);
    g = 0;
    while (!out_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!out_valid) fail("abort_wait_dout");
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ren_ext_2", ren_ext_2, 0);
    chk("abort_cpu_enable", cpu_enable, 0);
    ra_q.delete();
    rd_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_strobe", {ren_ext_2, wen_ext, ren_ext}, 0);
    end
    sink_mode = 0;

`ifdef EXT_MEM_LOADER_VERIFY_EN
    flip_idx = 2;
    exp_verr = 1;
    do_run(5, 0, 4, 10, 1, 0, 0);
    flip_idx = -1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_mem_loader.md
Name: ext_mem_loader

Overview:
- Host-side initiator for the CPU's external memory ports. It is the counterpart of the responder ports on the CPU top (addr_ext/wen_ext/… and addr_ext_2/…).
- Sequence per run:
  - streams a program from a valid/ready source into instruction memory;
  - holds cpu enable high for a programmed cycle count;
  - dumps a window of data memory out through a valid/ready sink.
- Sits between the testbench/host link and the CPU top. It replaces ad-hoc testbench tasks.

Parameters:
- IMEM_ADDR_W, 9, word-address width of instruction memory; max load = 2^IMEM_ADDR_W words.
- DMEM_ADDR_W, 10, word-address width of data memory; max dump = 2^DMEM_ADDR_W words.
- RD_LAT, 1, cycles from ren_ext_2 asserted to rdata_ext_2 valid (sram synchronous read).

Ports:
- clk  in  1  main clock
- srst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; accepted only in IDLE
- load_words  in  IMEM_ADDR_W+1  number of 32-bit program words to load (0 allowed)
- run_cycles  in  32  cycles to hold cpu_enable high
- dump_base  in  DMEM_ADDR_W  first data-memory word index to dump
- dump_words  in  DMEM_ADDR_W+1  number of 64-bit words to dump (0 allowed)
- in_valid  in  1  program word valid
- in_ready  out  1  loader accepts program word
- in_data  in  32  program word
- out_valid  out  1  dump word valid
- out_ready  in  1  sink accepts dump word
- out_data  out  64  dump word
- cpu_enable  out  1  drives CPU enable
- addr_ext  out  64  IMEM byte address
- wen_ext  out  1  IMEM write enable
- ren_ext  out  1  IMEM read enable
- wdata_ext  out  32  IMEM write data
- rdata_ext  in  32  IMEM read data (used only with the optional feature)
- addr_ext_2  out  64  DMEM byte address
- wen_ext_2  out  1  DMEM write enable; tied 0
- ren_ext_2  out  1  DMEM read enable
- wdata_ext_2  out  64  tied 0
- rdata_ext_2  in  64  DMEM read data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on the final dump handshake, or on a zero-length dump after RUN
- verify_err  out  1  sticky IMEM readback mismatch (optional feature)

Behaviour:
- Reset: srst is synchronous and active-high. On reset:
  - state=IDLE;
  - all outputs 0, all counters 0;
  - verify_err cleared.
- srst mid-operation aborts immediately to IDLE with no further memory strobes. The CPU's own state is not reset by this block.
- start is latched together with load_words, run_cycles, dump_base and dump_words. Later changes to these inputs are ignored until the next IDLE.
- Start pulses outside IDLE are ignored.

State machine:
- IDLE -> LOAD on start.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: wen_ext=1, addr_ext={idx,2'b00} zero-extended, wdata_ext=in_data, same cycle (combinational strobe from the handshake).
  - idx increments on each handshake.
  - When idx==load_words: go to VERIFY if enabled, else RUN.
  - load_words=0 skips straight out of LOAD next cycle.
- RUN:
  - cpu_enable=1 for exactly run_cycles clock cycles, then 0.
  - run_cycles=0 gives zero enabled cycles.
  - Then go to DREQ, or to IDLE with a done pulse if dump_words=0.
- DREQ:
  - ren_ext_2=1 for one cycle, addr_ext_2={dump_base+k,3'b000}.
  - Word index wraps modulo 2^DMEM_ADDR_W.
- DWAIT: RD_LAT cycles.
- DOUT:
  - Capture rdata_ext_2 into out_data and assert out_valid.
  - out_data is stable while out_valid&!out_ready.
  - On handshake: k++. If k==dump_words: done pulse, go to IDLE. Else go to DREQ.
- wen_ext and ren_ext_2 are never both asserted with cpu_enable.
- cpu_enable is 0 in every state except RUN.

Optional Feature:
- Macro: EXT_MEM_LOADER_VERIFY_EN.
- Defined:
  - VERIFY state after LOAD re-reads every loaded word (ren_ext=1, RD_LAT wait) and compares rdata_ext with a running copy.
  - Because no storage is allowed, the copy is a 32-bit XOR checksum of the words written and of the words read back.
  - verify_err is set if the two checksums differ. RUN proceeds regardless.
- Undefined: no VERIFY state, ren_ext tied 0, verify_err tied 0, rdata_ext unused.

Decomposition:
- Package ext_mem_loader_pkg:
  - state enum (IDLE, LOAD, VERIFY, RUN, DREQ, DWAIT, DOUT);
  - IMEM_BYTE_SHIFT=2, DMEM_BYTE_SHIFT=3;
  - address-formation functions.
- One sub-module: loader_down_counter, a loadable down-counter with zero flag. It is reused for the run cycles, the RD_LAT wait and the word counts.

Test Plan:
- Load 4 words 0x00000013… with in_valid always high: wen_ext on 4 consecutive cycles at addr 0,4,8,12; in_ready drops after the 4th handshake.
- Backpressure on the load (in_valid toggling 1,0,1,0): writes occur only on handshake cycles and the address sequence has no gaps.
- run_cycles=10: cpu_enable high for exactly 10 cycles. run_cycles=0: never high.
- dump_base=1023, dump_words=2, out_ready held low 3 cycles: addr_ext_2=0x1FF8 then 0x0; out_data held during the stall; done pulses on the second handshake.
- srst asserted in the middle of DOUT: next cycle IDLE, out_valid=0, busy=0, ren_ext_2=0.
- With EXT_MEM_LOADER_VERIFY_EN, force rdata_ext bit 0 flipped on word 2: verify_err=1 and RUN still entered.
